// File: rtl/uart_rx_ascii.sv
// 16x-oversampled 8N1 UART receiver feeding the ASCII display; strobes each good byte on newdata.
// Optional macro UART_RX_PARITY_EN switches the frame format to 8E1 and adds the parity_err output.
module uart_rx_ascii #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       newdata,
    output logic       baud,
    output logic       frame_err,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic       busy
);

    localparam int DIV   = CLK_HZ / (BAUD * OVERSAMPLE);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TW    = $clog2(OVERSAMPLE);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [TW-1:0]    T_LAST   = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0]    T_MID    = TW'(OVERSAMPLE / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    logic [DIV_W-1:0] div_cnt_reg;
    logic [1:0]       sync_reg;
    logic             rx_s;
    logic             tick;

    state_t     state_reg, state_next;
    logic [TW-1:0] tcnt_reg, tcnt_next;
    logic [2:0] bcnt_reg, bcnt_next;
    logic [7:0] shift_reg, shift_next;
    logic [7:0] data_reg, data_next;
    logic       newdata_reg, newdata_next;
    logic       frame_err_reg, frame_err_next;
`ifdef UART_RX_PARITY_EN
    logic       par_reg, par_next;
    logic       parity_err_reg, parity_err_next;
`endif

    // Free-running divider: never re-phased, so start detection carries up to one tick of phase error.
    assign tick = (div_cnt_reg == DIV_LAST);
    assign rx_s = sync_reg[1];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            div_cnt_reg    <= '0;
            sync_reg       <= 2'b11;
            state_reg      <= S_IDLE;
            tcnt_reg       <= '0;
            bcnt_reg       <= '0;
            shift_reg      <= '0;
            data_reg       <= '0;
            newdata_reg    <= 1'b0;
            frame_err_reg  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_reg        <= 1'b0;
            parity_err_reg <= 1'b0;
`endif
        end else begin
            div_cnt_reg    <= tick ? '0 : div_cnt_reg + 1'b1;
            sync_reg       <= {sync_reg[0], rx};
            state_reg      <= state_next;
            tcnt_reg       <= tcnt_next;
            bcnt_reg       <= bcnt_next;
            shift_reg      <= shift_next;
            data_reg       <= data_next;
            newdata_reg    <= newdata_next;
            frame_err_reg  <= frame_err_next;
`ifdef UART_RX_PARITY_EN
            par_reg        <= par_next;
            parity_err_reg <= parity_err_next;
`endif
        end
    end

    always_comb begin
        state_next      = state_reg;
        tcnt_next       = tcnt_reg;
        bcnt_next       = bcnt_reg;
        shift_next      = shift_reg;
        data_next       = data_reg;
        newdata_next    = 1'b0;
        frame_err_next  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_next        = par_reg;
        parity_err_next = 1'b0;
`endif
        if (tick) begin
            case (state_reg)
                S_IDLE: begin
                    if (!rx_s) begin
                        state_next = S_START;
                        tcnt_next  = '0;
                    end
                end
                S_START: begin
                    if (tcnt_reg == T_MID) begin
                        // A start bit that is high again at its midpoint was only a glitch.
                        if (!rx_s) begin
                            state_next = S_DATA;
                            tcnt_next  = '0;
                            bcnt_next  = '0;
                        end else begin
                            state_next = S_IDLE;
                        end
                    end else begin
                        tcnt_next = tcnt_reg + 1'b1;
                    end
                end
                S_DATA: begin
                    if (tcnt_reg == T_LAST) begin
                        shift_next = {rx_s, shift_reg[7:1]};
                        tcnt_next  = '0;
                        if (bcnt_reg == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_next = S_PARITY;
`else
                            state_next = S_STOP;
`endif
                        end else begin
                            bcnt_next = bcnt_reg + 1'b1;
                        end
                    end else begin
                        tcnt_next = tcnt_reg + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (tcnt_reg == T_LAST) begin
                        par_next   = rx_s;
                        tcnt_next  = '0;
                        state_next = S_STOP;
                    end else begin
                        tcnt_next = tcnt_reg + 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    // Leaving at mid-stop lets a back-to-back start edge be caught on the next tick.
                    if (tcnt_reg == T_LAST) begin
                        state_next = S_IDLE;
                        if (rx_s) begin
`ifdef UART_RX_PARITY_EN
                            if (^{shift_reg, par_reg}) begin
                                parity_err_next = 1'b1;
                            end else begin
                                data_next    = shift_reg;
                                newdata_next = 1'b1;
                            end
`else
                            data_next    = shift_reg;
                            newdata_next = 1'b1;
`endif
                        end else begin
                            frame_err_next = 1'b1;
                        end
                    end else begin
                        tcnt_next = tcnt_reg + 1'b1;
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    assign data      = data_reg;
    assign newdata   = newdata_reg;
    assign frame_err = frame_err_reg;
    assign baud      = tick;
    assign busy      = (state_reg != S_IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_reg;
`endif

endmodule

// File: tb/tb_uart_rx_ascii.sv
// Directed bench for uart_rx_ascii at DIV=10 (160 clk per bit); a scoreboard queue holds expected bytes.
module tb_uart_rx_ascii;

    localparam int CLK_HZ  = 1_600_000;
    localparam int BAUD    = 10_000;
    localparam int OS      = 16;
    localparam int BIT_CLK = 160;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] data;
    logic       newdata;
    logic       baud;
    logic       frame_err;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    uart_rx_ascii #(
        .CLK_HZ(CLK_HZ),
        .BAUD(BAUD),
        .OVERSAMPLE(OS)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .rx(rx),
        .data(data),
        .newdata(newdata),
        .baud(baud),
        .frame_err(frame_err),
`ifdef UART_RX_PARITY_EN
        .parity_err(parity_err),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    int cyc    = 0;

    logic [7:0] exp_q[$];
    int nd_cnt = 0;
    int fe_cnt = 0;
    int pe_cnt = 0;
    int last_nd_cyc = 0;
    int prev_nd_cyc = 0;
    int frame_start_cyc = 0;
    logic       busy_prev = 1'b0;
    logic [7:0] data_prev = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every newdata and counts error strobes.
    always @(negedge clk) begin
        if (reset_n) begin
            if (newdata || frame_err)
                check("single strobe", 32'(newdata & frame_err), 32'd0);
            if (newdata) begin
                nd_cnt++;
                prev_nd_cyc = last_nd_cyc;
                last_nd_cyc = cyc;
                $display("newdata: data=0x%02h at cycle %0d", data, cyc);
                check("newdata expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0)
                    check("data", 32'(data), 32'(exp_q.pop_front()));
                check("busy falls with newdata", 32'({busy_prev, busy}), 32'b10);
            end
            if (frame_err) begin
                fe_cnt++;
                $display("frame_err at cycle %0d", cyc);
            end
`ifdef UART_RX_PARITY_EN
            if (parity_err) begin
                pe_cnt++;
                $display("parity_err at cycle %0d", cyc);
            end
`endif
            if (!newdata && data !== data_prev)
                check("data stable", 32'(data), 32'(data_prev));
        end
        busy_prev = busy;
        data_prev = data;
    end

    task automatic drive_bit(input logic v);
        rx = v;
        repeat (BIT_CLK) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit, input logic par_flip);
        if (stop_bit && !par_flip)
            exp_q.push_back(b);
        frame_start_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++)
            drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit((^b) ^ par_flip);
`endif
        drive_bit(stop_bit);
        rx = 1'b1;
    endtask

    task automatic idle_bits(input int n);
        rx = 1'b1;
        repeat (n * BIT_CLK) @(negedge clk);
    endtask

    initial begin
        int lat;
        int gap;
        int n;

        // Reset values
        reset_n = 1'b0;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        check("reset data", 32'(data), 32'h00);
        check("reset newdata", 32'(newdata), 32'd0);
        check("reset frame_err", 32'(frame_err), 32'd0);
        check("reset baud", 32'(baud), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        reset_n = 1'b1;
        idle_bits(2);
        check("idle after reset", 32'(busy), 32'd0);

        // 1. Single byte
        send_byte(8'h41, 1'b1, 1'b0);
        idle_bits(2);
        check("t1 newdata count", 32'(nd_cnt), 32'd1);
        check("t1 frame_err count", 32'(fe_cnt), 32'd0);
        check("t1 data", 32'(data), 32'h41);
        lat = last_nd_cyc - frame_start_cyc;
        $display("t1 latency %0d cycles", lat);
        check("t1 latency window", 32'(lat >= 1520 && lat <= 1535), 32'd1);

        // 2. Glitch rejection, aligned so the start edge lands just before a tick
        n = 0;
        while (!baud && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("baud tick seen", 32'(baud), 32'd1);
        repeat (7) @(negedge clk);
        rx = 1'b0;
        repeat (40) @(negedge clk);
        rx = 1'b1;
        check("t2 busy during glitch", 32'(busy), 32'd1);
        repeat (50) @(negedge clk);
        check("t2 idle by 90 clk", 32'(busy), 32'd0);
        idle_bits(1);
        check("t2 newdata count", 32'(nd_cnt), 32'd1);
        check("t2 frame_err count", 32'(fe_cnt), 32'd0);

        // 3. Framing error
        send_byte(8'h41, 1'b1, 1'b0);
        idle_bits(2);
        send_byte(8'h55, 1'b0, 1'b0);
        idle_bits(3);
        check("t3 frame_err count", 32'(fe_cnt), 32'd1);
        check("t3 newdata count", 32'(nd_cnt), 32'd2);
        check("t3 data held", 32'(data), 32'h41);

        // 4. Back-to-back frames
        send_byte(8'h48, 1'b1, 1'b0);
        send_byte(8'h69, 1'b1, 1'b0);
        idle_bits(2);
        check("t4 newdata count", 32'(nd_cnt), 32'd4);
        gap = last_nd_cyc - prev_nd_cyc;
        $display("t4 newdata gap %0d cycles", gap);
        check("t4 gap window", 32'(gap >= 1590 && gap <= 1610), 32'd1);
        check("t4 data", 32'(data), 32'h69);

        // 5. Reset in the middle of bit 3 of 0x7A
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++)
            drive_bit(n[0] | 1'b0 ? 1'b0 : 1'b0 | ((8'h7A >> i) & 8'h01) != 0);
        rx = 1'b1;
        repeat (BIT_CLK / 2) @(negedge clk);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("t5 data after reset", 32'(data), 32'h00);
        check("t5 busy after reset", 32'(busy), 32'd0);
        reset_n = 1'b1;
        idle_bits(2);
        send_byte(8'h30, 1'b1, 1'b0);
        idle_bits(2);
        check("t5 newdata count", 32'(nd_cnt), 32'd5);
        check("t5 data", 32'(data), 32'h30);
        check("t5 frame_err count", 32'(fe_cnt), 32'd1);

`ifdef UART_RX_PARITY_EN
        // 6. Even parity good and bad
        send_byte(8'h41, 1'b1, 1'b0);
        idle_bits(2);
        check("t6 good parity newdata", 32'(nd_cnt), 32'd6);
        check("t6 good parity data", 32'(data), 32'h41);
        send_byte(8'h55, 1'b1, 1'b1);
        idle_bits(2);
        check("t6 parity_err count", 32'(pe_cnt), 32'd1);
        check("t6 bad parity no newdata", 32'(nd_cnt), 32'd6);
        check("t6 bad parity data held", 32'(data), 32'h41);
`endif

        check("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
